// File: rtl/lzss_decoder.sv
// lzss_decoder
//   Reconstructs a WORD_SIZE-bit word stream from (WORD_SIZE+1)-bit LZSS
//   tokens. A token with a clear MSB is a literal word; a token with a set MSB
//   is a back-reference (offset, length) into the last WINDOW_SIZE emitted
//   words. One decoded word per cycle when the sink keeps out_ready high.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   token present on in_data
//   in_data    token: [WORD_SIZE] ref flag, literal in [WORD_SIZE-1:0],
//              ref offset in the top OFF_W bits, ref length in the low LEN_W bits
//   in_ready   token taken on in_valid && in_ready
//   out_valid  out_data holds a decoded word
//   out_data   decoded word (registered)
//   out_ready  sink takes the word on out_valid && out_ready
//   busy       high while a multi-word reference is being expanded
module lzss_decoder #(
  parameter int WORD_SIZE       = 8,
  parameter int WINDOW_SIZE     = 16,
  parameter int LOOK_AHEAD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WORD_SIZE:0]   in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int OFF_W = $clog2(WINDOW_SIZE);
  localparam int LEN_W = $clog2(LOOK_AHEAD_SIZE);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [OFF_W-1:0]     r_off;
  logic [OFF_W-1:0]     w_off_next;
  logic [LEN_W-1:0]     r_rem;
  logic [LEN_W-1:0]     w_rem_next;
  logic                 r_out_valid;
  logic [WORD_SIZE-1:0] r_out_data;

  // hist[0] is the most recently emitted word
  logic [WORD_SIZE-1:0] r_hist [WINDOW_SIZE];

  logic                 w_slot_free;
  logic                 w_accept;
  logic                 w_is_ref;
  logic [OFF_W-1:0]     w_tok_off;
  logic [LEN_W-1:0]     w_tok_len;
  logic                 w_load;
  logic [WORD_SIZE-1:0] w_load_word;

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == IDLE) && w_slot_free;
  assign w_accept    = in_valid && in_ready;
  assign w_is_ref    = in_data[WORD_SIZE];
  assign w_tok_off   = in_data[WORD_SIZE-1 -: OFF_W];
  assign w_tok_len   = in_data[LEN_W-1:0];

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == COPY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_off   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_next;
      r_off   <= w_off_next;
      r_rem   <= w_rem_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_off_next   = r_off;
    w_rem_next   = r_rem;
    w_load       = 1'b0;
    w_load_word  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_is_ref) begin
            // First word of the reference leaves on the accept edge; the
            // remaining len words are produced from COPY.
            w_load_word = r_hist[w_tok_off];
            w_off_next  = w_tok_off;
            w_rem_next  = w_tok_len;
            if (w_tok_len != '0) begin
              w_state_next = COPY;
            end
          end else begin
            w_load_word = in_data[WORD_SIZE-1:0];
          end
        end
      end
      COPY: begin
        if (w_slot_free) begin
          // The window shifts each load, so a fixed offset naturally handles
          // overlapping copies (distance < length).
          w_load      = 1'b1;
          w_load_word = r_hist[r_off];
          w_rem_next  = r_rem - LEN_ONE;
          if (r_rem == LEN_ONE) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_word;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_load) begin
      r_hist[0] <= w_load_word;
      for (int i = 1; i < WINDOW_SIZE; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

endmodule

// File: tb/tb_lzss_decoder.sv
// tb_lzss_decoder
//   Directed-vector bench for lzss_decoder. Inputs change and outputs are
//   sampled on the falling edge, half a cycle away from the active edge.
module tb_lzss_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [8:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  int n_checks;
  int n_fails;

  lzss_decoder #(
    .WORD_SIZE      (8),
    .WINDOW_SIZE    (16),
    .LOOK_AHEAD_SIZE(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Check a presented output word together with the control flags.
  task automatic expect_word(input string tag, input logic [7:0] w,
                             input logic bsy, input logic rdy);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(w));
    check({tag, ".busy"},  32'(busy),      32'(bsy));
    check({tag, ".ready"}, 32'(in_ready),  32'(rdy));
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.ready", 32'(in_ready),  32'd1);
    check("rst.data",  32'(out_data),  32'd0);

    // Back-to-back literals A, B, C
    in_valid = 1'b1; in_data = 9'h041;
    tick(); expect_word("litA", 8'h41, 1'b0, 1'b1);
    in_data = 9'h042;
    tick(); expect_word("litB", 8'h42, 1'b0, 1'b1);
    in_data = 9'h043;
    tick(); expect_word("litC", 8'h43, 1'b0, 1'b1);

    // Reference distance 3, length 4
    in_data = 9'h123;
    tick(); expect_word("ref123.0", 8'h41, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); expect_word("ref123.1", 8'h42, 1'b1, 1'b0);
    tick(); expect_word("ref123.2", 8'h43, 1'b1, 1'b0);
    tick(); expect_word("ref123.3", 8'h41, 1'b0, 1'b1);
    tick(); check("ref123.drain", 32'(out_valid), 32'd0);

    // Literal then overlapping reference distance 1, length 4
    in_valid = 1'b1; in_data = 9'h055;
    tick(); expect_word("lit55", 8'h55, 1'b0, 1'b1);
    in_data = 9'h103;
    tick(); expect_word("ovl.0", 8'h55, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick(); expect_word("ovl.1", 8'h55, 1'b1, 1'b0);
    tick(); expect_word("ovl.2", 8'h55, 1'b1, 1'b0);
    tick(); expect_word("ovl.3", 8'h55, 1'b0, 1'b1);

    // Backpressure in the middle of ref 0x123
    in_valid = 1'b1; in_data = 9'h041;
    tick(); expect_word("bp.litA", 8'h41, 1'b0, 1'b1);
    in_data = 9'h042;
    tick(); expect_word("bp.litB", 8'h42, 1'b0, 1'b1);
    in_data = 9'h043;
    tick(); expect_word("bp.litC", 8'h43, 1'b0, 1'b1);
    in_data = 9'h123;
    tick(); expect_word("bp.0", 8'h41, 1'b1, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_word($sformatf("bp.hold%0d", i), 8'h41, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    tick(); expect_word("bp.1", 8'h42, 1'b1, 1'b0);
    tick(); expect_word("bp.2", 8'h43, 1'b1, 1'b0);
    tick(); expect_word("bp.3", 8'h41, 1'b0, 1'b1);
    tick(); check("bp.drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a COPY; history must be cleared afterwards
    in_valid = 1'b1; in_data = 9'h103;
    tick(); check("midrst.busy_before", 32'(busy), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.busy",  32'(busy),      32'd0);
    check("midrst.ready", 32'(in_ready),  32'd1);
    in_valid = 1'b1; in_data = 9'h100;
    tick(); expect_word("midrst.ref100", 8'h00, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("midrst.drain", 32'(out_valid), 32'd0);
    check("midrst.noextra_busy", 32'(busy), 32'd0);

    // Distance 16, length 1 straight after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("far.ready_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 9'h1F0;
    tick(); expect_word("far.word", 8'h00, 1'b0, 1'b1);
    in_valid = 1'b0;
    tick();
    check("far.drain", 32'(out_valid), 32'd0);
    check("far.busy",  32'(busy),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lzss_decoder.md
Name: lzss_decoder

Overview:
- Inverse of the LZSS encoder: consumes (WORD_SIZE+1)-bit tokens and reconstructs the original WORD_SIZE-bit byte stream.
- Token MSB = 0: literal. Token MSB = 1: back-reference into a WINDOW_SIZE-deep history of previously emitted words.
- Sits downstream of the encoder (or of a token FIFO) and feeds the decompressed-data sink.
- Valid/ready handshakes on both sides; sustained throughput 1 word/cycle.

Parameters:
- WORD_SIZE, 8, data word width in bits; token width is WORD_SIZE+1.
- WINDOW_SIZE, 16, history depth in words; OFF_W = clog2(WINDOW_SIZE).
- LOOK_AHEAD_SIZE, 4, maximum reference length; LEN_W = clog2(LOOK_AHEAD_SIZE). Requires OFF_W+LEN_W <= WORD_SIZE.

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  token present on in_data
- in_data  in  WORD_SIZE+1  token: [WORD_SIZE] = ref flag; literal word in [WORD_SIZE-1:0]
- in_ready  out  1  token is accepted on a cycle with in_valid && in_ready
- out_valid  out  1  out_data holds a decoded word
- out_data  out  WORD_SIZE  decoded word
- out_ready  in  1  sink accepts the word on a cycle with out_valid && out_ready
- busy  out  1  high while in COPY state

Behaviour:
- Reference token fields:
  - in_data[WORD_SIZE-1 -: OFF_W] = off; distance = off+1 (1..WINDOW_SIZE).
  - in_data[LEN_W-1:0] = len; length = len+1 (1..LOOK_AHEAD_SIZE).
  - Bits between the two fields are ignored.
  - Defaults: [7:4] off, [3:2] ignored, [1:0] len.
- History: shift register hist[0..WINDOW_SIZE-1] of words, hist[0] = most recent.
  - Every word loaded into the output register is shifted in at hist[0] on that same edge.
  - Reset clears hist to 0, so a reference into unwritten history yields 0x00.
- Output register: out_data/out_valid are registered. Load is allowed when !out_valid || out_ready ("slot free").
- States: IDLE, COPY.
  - in_ready = (state==IDLE) && slot free. in_ready is 0 throughout COPY.
  - IDLE, literal accepted: out_data <= literal; out_valid <= 1; shift literal into hist. Stay IDLE.
  - IDLE, reference accepted: out_data <= hist[off]; shift that word into hist. Latch off; remaining = len.
    - If len == 0, stay IDLE.
    - Otherwise go to COPY.
  - COPY, slot free: out_data <= hist[off_latched]; shift it in; decrement remaining.
    - On the edge where remaining goes 1 -> 0, return to IDLE.
    - Remaining words emitted in COPY = len, so total words out per reference = len+1.
  - COPY, slot not free: hold all state. out_data stays stable while out_valid && !out_ready.
- Overlapping copies (distance < length) work natively: the distance is fixed relative to the shifting window, e.g. distance 1 repeats the last word.
- Latency: token accepted at edge N -> first decoded word on out_valid after edge N; one word per cycle thereafter while out_ready=1.
- A reference of length L blocks input for L-1 additional cycles (plus any backpressure cycles).
- out_valid drops to 0 after a handshake when no new word is loaded that edge.
- Reset (any state, including mid-COPY):
  - state = IDLE, out_valid = 0, out_data = 0, busy = 0, hist = 0, counters = 0.
  - Any in-flight reference is discarded.
  - in_ready = 1 in the first cycle after reset (slot is empty).
- busy = (state==COPY).

Test Plan:
- Reset, then literals 0x041, 0x042, 0x043 back-to-back with out_ready=1 -> out_data 0x41, 0x42, 0x43 on consecutive cycles, each one cycle after acceptance; in_ready held 1.
- After A, B, C, send ref 0x123 (distance 3, length 4) -> out 0x41, 0x42, 0x43, 0x41; in_ready low for 3 cycles; busy high for 3 cycles.
- Literal 0x055 then ref 0x103 (distance 1, length 4) -> 0x55 followed by four 0x55 words (overlap case).
- Ref 0x1F0 (distance 16, length 1) immediately after reset -> a single 0x00 word; no COPY entry.
- During ref 0x123, drop out_ready for 3 cycles mid-copy -> out_data/out_valid held stable; remaining words unchanged; sequence completes correctly after out_ready returns.
- Assert rst during COPY of ref 0x103 -> next cycle out_valid=0, busy=0, in_ready=1; a subsequent ref 0x100 outputs 0x00 (history cleared).
